// File: rtl/el2_lsu_dccm_stbuf_pkg.sv
// rtl/el2_lsu_dccm_stbuf_pkg.sv - shared types and sizes for the DCCM store buffer
package el2_lsu_dccm_stbuf_pkg;

  localparam int STBUF_DEPTH   = 4;
  localparam int STBUF_ADDR_W  = 16;
  localparam int STBUF_FDATA_W = 39;
  localparam int STBUF_WIDTH_B = 2;
  // One extra bit so full and empty can be told apart with equal indices
  localparam int STBUF_PTR_W   = $clog2(STBUF_DEPTH) + 1;

  typedef struct packed {
    logic [STBUF_ADDR_W-1:0]  addr_lo;
    logic [STBUF_ADDR_W-1:0]  addr_hi;
    logic [STBUF_FDATA_W-1:0] data_lo;
    logic [STBUF_FDATA_W-1:0] data_hi;
  } stbuf_entry_t;

endpackage

// File: rtl/el2_lsu_stbuf_fwd_sel.sv
// rtl/el2_lsu_stbuf_fwd_sel.sv - age-ordered select of the youngest buffered word matching a load address
module el2_lsu_stbuf_fwd_sel
  import el2_lsu_dccm_stbuf_pkg::*;
#(
  parameter int DEPTH   = STBUF_DEPTH,
  parameter int ADDR_W  = STBUF_ADDR_W,
  parameter int FDATA_W = STBUF_FDATA_W,
  parameter int WIDTH_B = STBUF_WIDTH_B,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]   valid,
  input  stbuf_entry_t       entries [DEPTH],
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [ADDR_W-1:0]  ld_addr,
  output logic               hit,
  output logic [FDATA_W-1:0] data
);

  // Walk oldest to youngest so the last match (youngest) overrides; within an
  // entry the lo half is checked last, which matters only for aligned stores.
  always_comb begin
    logic [IDX_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + k[IDX_W-1:0];
      if (valid[idx]) begin
        if (entries[idx].addr_hi[ADDR_W-1:WIDTH_B] == ld_addr[ADDR_W-1:WIDTH_B]) begin
          hit  = 1'b1;
          data = entries[idx].data_hi;
        end
        if (entries[idx].addr_lo[ADDR_W-1:WIDTH_B] == ld_addr[ADDR_W-1:WIDTH_B]) begin
          hit  = 1'b1;
          data = entries[idx].data_lo;
        end
      end
    end
  end

endmodule

// File: rtl/el2_lsu_dccm_stbuf.sv
// rtl/el2_lsu_dccm_stbuf.sv - DCCM store buffer with drain arbitration; DCCM_STBUF_FWD_EN enables load forwarding
module el2_lsu_dccm_stbuf
  import el2_lsu_dccm_stbuf_pkg::*;
#(
  parameter int DEPTH   = STBUF_DEPTH,
  parameter int ADDR_W  = STBUF_ADDR_W,
  parameter int FDATA_W = STBUF_FDATA_W,
  parameter int WIDTH_B = STBUF_WIDTH_B
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [ADDR_W-1:0]  st_addr_lo,
  input  logic [ADDR_W-1:0]  st_addr_hi,
  input  logic [FDATA_W-1:0] st_data_lo,
  input  logic [FDATA_W-1:0] st_data_hi,
  input  logic               ld_rden,
  input  logic [ADDR_W-1:0]  ld_addr_lo,
  input  logic [ADDR_W-1:0]  ld_addr_hi,
  output logic               ld_stall,
  input  logic               fence_req,
  output logic               dccm_wren,
  output logic [ADDR_W-1:0]  dccm_wr_addr_lo,
  output logic [ADDR_W-1:0]  dccm_wr_addr_hi,
  output logic [FDATA_W-1:0] dccm_wr_data_lo,
  output logic [FDATA_W-1:0] dccm_wr_data_hi,
  output logic               fwd_hit_lo,
  output logic               fwd_hit_hi,
  output logic [FDATA_W-1:0] fwd_data_lo,
  output logic [FDATA_W-1:0] fwd_data_hi,
  output logic               stbuf_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = STBUF_PTR_W;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] valid;
  stbuf_entry_t     entries [DEPTH];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push, drain, ld_conflict;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr == rd_ptr);

  assign st_ready    = !full;
  assign stbuf_empty = empty;
  assign push        = st_valid & st_ready;

`ifdef DCCM_STBUF_FWD_EN
  el2_lsu_stbuf_fwd_sel #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FDATA_W(FDATA_W), .WIDTH_B(WIDTH_B)
  ) u_fwd_lo (
    .valid(valid), .entries(entries), .rd_idx(rd_idx),
    .ld_addr(ld_addr_lo), .hit(fwd_hit_lo), .data(fwd_data_lo)
  );

  el2_lsu_stbuf_fwd_sel #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FDATA_W(FDATA_W), .WIDTH_B(WIDTH_B)
  ) u_fwd_hi (
    .valid(valid), .entries(entries), .rd_idx(rd_idx),
    .ld_addr(ld_addr_hi), .hit(fwd_hit_hi), .data(fwd_data_hi)
  );

  assign ld_conflict = 1'b0;
`else
  // Without forwarding a load touching a buffered word must wait for it to drain
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && ld_rden &&
          ((entries[i].addr_lo[ADDR_W-1:WIDTH_B] == ld_addr_lo[ADDR_W-1:WIDTH_B]) ||
           (entries[i].addr_lo[ADDR_W-1:WIDTH_B] == ld_addr_hi[ADDR_W-1:WIDTH_B]) ||
           (entries[i].addr_hi[ADDR_W-1:WIDTH_B] == ld_addr_lo[ADDR_W-1:WIDTH_B]) ||
           (entries[i].addr_hi[ADDR_W-1:WIDTH_B] == ld_addr_hi[ADDR_W-1:WIDTH_B])))
        ld_conflict = 1'b1;
    end
  end

  assign fwd_hit_lo  = 1'b0;
  assign fwd_hit_hi  = 1'b0;
  assign fwd_data_lo = '0;
  assign fwd_data_hi = '0;
`endif

  assign drain    = !empty & (!ld_rden | full | fence_req | ld_conflict);
  assign ld_stall = drain & ld_rden;

  assign dccm_wren       = drain;
  assign dccm_wr_addr_lo = entries[rd_idx].addr_lo;
  assign dccm_wr_addr_hi = entries[rd_idx].addr_hi;
  assign dccm_wr_data_lo = entries[rd_idx].data_lo;
  assign dccm_wr_data_hi = entries[rd_idx].data_hi;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        valid[wr_idx]  <= 1'b1;
      end
      if (drain) begin
        rd_ptr         <= rd_ptr + 1'b1;
        valid[rd_idx]  <= 1'b0;
      end
    end
  end

  // Entry payload needs no reset: it is only observed through a valid bit
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_idx] <= '{addr_lo: st_addr_lo, addr_hi: st_addr_hi,
                           data_lo: st_data_lo, data_hi: st_data_hi};
    end
  end

endmodule

// File: tb/tb_el2_lsu_dccm_stbuf.sv
// tb/tb_el2_lsu_dccm_stbuf.sv - randomized scoreboard bench for the DCCM store buffer
module tb_el2_lsu_dccm_stbuf;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] alo;
    logic [15:0] ahi;
    logic [38:0] dlo;
    logic [38:0] dhi;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        st_valid = 1'b0, st_ready;
  logic [15:0] st_addr_lo = '0, st_addr_hi = '0;
  logic [38:0] st_data_lo = '0, st_data_hi = '0;
  logic        ld_rden = 1'b0;
  logic [15:0] ld_addr_lo = '0, ld_addr_hi = '0;
  logic        ld_stall, fence_req = 1'b0, dccm_wren;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic        fwd_hit_lo, fwd_hit_hi;
  logic [38:0] fwd_data_lo, fwd_data_hi;
  logic        stbuf_empty;

  int errors = 0;
  int checks = 0;

  st_t mdl[$];
  st_t exp_wr_q[$];

  el2_lsu_dccm_stbuf dut (
    .clk(clk), .rst_l(rst_l),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr_lo(st_addr_lo), .st_addr_hi(st_addr_hi),
    .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
    .ld_rden(ld_rden), .ld_addr_lo(ld_addr_lo), .ld_addr_hi(ld_addr_hi),
    .ld_stall(ld_stall), .fence_req(fence_req),
    .dccm_wren(dccm_wren),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .fwd_hit_lo(fwd_hit_lo), .fwd_hit_hi(fwd_hit_hi),
    .fwd_data_lo(fwd_data_lo), .fwd_data_hi(fwd_data_hi),
    .stbuf_empty(stbuf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[38:0];
  endfunction

  // Youngest buffered store wins; within a store the lo word is taken first
  function automatic void lookup(input logic [15:0] a, output bit hit, output logic [38:0] d);
    hit = 0;
    d   = '0;
    for (int i = mdl.size() - 1; i >= 0; i--) begin
      if (mdl[i].alo[15:2] == a[15:2]) begin hit = 1; d = mdl[i].dlo; break; end
      if (mdl[i].ahi[15:2] == a[15:2]) begin hit = 1; d = mdl[i].dhi; break; end
    end
  endfunction

  task automatic cyc(input bit sv, input logic [15:0] alo, input logic [15:0] ahi,
                     input logic [38:0] dlo, input logic [38:0] dhi,
                     input bit rd, input logic [15:0] llo, input logic [15:0] lhi, input bit fn);
    bit          full, exp_drain, exp_stall, conflict, hl, hh;
    logic [38:0] dl, dh;
    st_t         e;
    @(negedge clk);
    st_valid = sv; st_addr_lo = alo; st_addr_hi = ahi; st_data_lo = dlo; st_data_hi = dhi;
    ld_rden = rd; ld_addr_lo = llo; ld_addr_hi = lhi; fence_req = fn;
    #1;
    full = (mdl.size() == DEPTH);
    lookup(llo, hl, dl);
    lookup(lhi, hh, dh);
`ifdef DCCM_STBUF_FWD_EN
    conflict = 0;
    chk("fwd_hit_lo", 64'(fwd_hit_lo), 64'(hl));
    chk("fwd_hit_hi", 64'(fwd_hit_hi), 64'(hh));
    if (hl) chk("fwd_data_lo", 64'(fwd_data_lo), 64'(dl));
    if (hh) chk("fwd_data_hi", 64'(fwd_data_hi), 64'(dh));
`else
    conflict = rd && (hl || hh);
    chk("fwd_hit_lo", 64'(fwd_hit_lo), 64'(0));
    chk("fwd_hit_hi", 64'(fwd_hit_hi), 64'(0));
    chk("fwd_data_lo", 64'(fwd_data_lo), 64'(0));
`endif
    exp_drain = (mdl.size() > 0) && (!rd || full || fn || conflict);
    exp_stall = exp_drain && rd;
    chk("st_ready", 64'(st_ready), 64'(!full));
    chk("dccm_wren", 64'(dccm_wren), 64'(exp_drain));
    chk("ld_stall", 64'(ld_stall), 64'(exp_stall));
    chk("stbuf_empty", 64'(stbuf_empty), 64'(mdl.size() == 0));
    @(posedge clk);
    if (exp_drain) void'(mdl.pop_front());
    if (sv && !full) begin
      e = '{alo: alo, ahi: ahi, dlo: dlo, dhi: dhi};
      mdl.push_back(e);
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic idle(input bit rd);
    cyc(0, '0, '0, '0, '0, rd, 16'h0F00, 16'h0F00, 0);
  endtask

  task automatic store(input logic [15:0] alo, input logic [15:0] ahi, input bit rd);
    logic [38:0] d;
    d = rnd_data();
    cyc(1, alo, ahi, d, (alo == ahi) ? d : rnd_data(), rd, 16'h0F00, 16'h0F00, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    st_valid = 0; fence_req = 0; ld_rden = 1;
    rst_l = 0;
    #1;
    mdl.delete();
    exp_wr_q.delete();
    chk("rst_dccm_wren", 64'(dccm_wren), 64'(0));
    chk("rst_stbuf_empty", 64'(stbuf_empty), 64'(1));
    chk("rst_st_ready", 64'(st_ready), 64'(1));
    chk("rst_ld_stall", 64'(ld_stall), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_l = 1;
  endtask

  // Monitor: every write the DUT presents must be the oldest accepted store
  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_l && dccm_wren === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_wren", 64'(dccm_wren), 64'(0));
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr_lo", 64'(dccm_wr_addr_lo), 64'(e.alo));
          chk("wr_addr_hi", 64'(dccm_wr_addr_hi), 64'(e.ahi));
          chk("wr_data_lo", 64'(dccm_wr_data_lo), 64'(e.dlo));
          chk("wr_data_hi", 64'(dccm_wr_data_hi), 64'(e.dhi));
        end
      end
    end
  end

  initial begin
    logic [15:0] a, la;
    logic [38:0] d;
    bit          fn, sv;
    #2;
    chk("reset_st_ready", 64'(st_ready), 64'(1));
    chk("reset_empty", 64'(stbuf_empty), 64'(1));
    chk("reset_wren", 64'(dccm_wren), 64'(0));
    chk("reset_stall", 64'(ld_stall), 64'(0));
    chk("reset_fwd_hit_lo", 64'(fwd_hit_lo), 64'(0));
    @(negedge clk);
    rst_l = 1;

    cyc(1, 16'h0100, 16'h0100, 39'h11, 39'h11, 0, 16'h0F00, 16'h0F00, 0);
    idle(0);
    idle(0);

    for (int i = 0; i < 4; i++) store(16'h0200 + 16'(4 * i), 16'h0200 + 16'(4 * i), 1);
    d = rnd_data();
    cyc(1, 16'h0300, 16'h0300, d, d, 1, 16'h0F00, 16'h0F00, 0);
    cyc(1, 16'h0300, 16'h0300, d, d, 1, 16'h0F00, 16'h0F00, 0);
    repeat (6) idle(0);

    cyc(1, 16'h0104, 16'h0104, 39'hA, 39'hA, 1, 16'h0F00, 16'h0F00, 0);
    cyc(1, 16'h0104, 16'h0104, 39'hB, 39'hB, 1, 16'h0F00, 16'h0F00, 0);
    cyc(0, '0, '0, '0, '0, 1, 16'h0104, 16'h0108, 0);
    repeat (3) idle(0);

    cyc(1, 16'h01FC, 16'h0200, 39'h1C, 39'h2D, 1, 16'h0F00, 16'h0F00, 0);
    cyc(0, '0, '0, '0, '0, 1, 16'h0200, 16'h0204, 0);
    repeat (3) idle(0);

    for (int i = 0; i < 3; i++) store(16'h0400 + 16'(8 * i), 16'h0404 + 16'(8 * i), 1);
    repeat (3) cyc(0, '0, '0, '0, '0, 1, 16'h0F00, 16'h0F00, 1);
    idle(1);

    store(16'h0500, 16'h0500, 1);
    store(16'h0504, 16'h0504, 1);
    do_reset();
    store(16'h0120, 16'h0120, 1);
    store(16'h0124, 16'h0124, 1);
    repeat (3) cyc(0, '0, '0, '0, '0, 1, 16'h0124, 16'h0124, 0);
    repeat (3) idle(0);

    for (int n = 0; n < 400; n++) begin
      a  = 16'h0100 + 16'(4 * $urandom_range(0, 7));
      la = 16'h0100 + 16'(4 * $urandom_range(0, 9));
      fn = ($urandom % 8) == 0;
      sv = !fn && ($urandom % 2);
      d  = rnd_data();
      if ($urandom % 2)
        cyc(sv, a, a, d, d, ($urandom % 4) != 0, la, la, fn);
      else
        cyc(sv, a, a + 16'h4, d, rnd_data(), ($urandom % 4) != 0, la, la + 16'h4, fn);
      if (n == 200) do_reset();
    end

    repeat (DEPTH + 2) idle(0);
    @(negedge clk);
    #3;
    chk("final_empty", 64'(stbuf_empty), 64'(1));
    chk("scoreboard_drained", 64'(exp_wr_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
